// File: rtl/dca_block_sequencer_mc_if.sv
// ---------------------------------------------------------------------------
// dca_block_sequencer_mc_if
// Bundles the instruction, step and LSU request signals of the block
// sequencer.
//   master : the sequencer (accepts instructions, issues steps/LSU requests)
//   slave  : the environment (instruction queue, compute engine, LSU array)
// Signals:
//   enable, busy                       global qualifier / activity status
//   inst_*                             instruction offer and fields
//   step_*                             step offer to the compute engine
//   lsu_req_valid/ready/write          per-channel LSU requests
// ---------------------------------------------------------------------------
interface dca_block_sequencer_mc_if #(
  parameter int NUM_CH = 3,
  parameter int BW_DIM = 8
);
  logic                enable;
  logic                busy;
  logic                inst_valid;
  logic                inst_ready;
  logic [BW_DIM-1:0]   inst_num_m;
  logic [BW_DIM-1:0]   inst_num_n;
  logic [BW_DIM-1:0]   inst_num_k;
  logic [NUM_CH-1:0]   inst_ch_mask;
  logic                inst_col_first;
  logic                inst_load_acc;
  logic                step_valid;
  logic                step_ready;
  logic [BW_DIM-1:0]   step_m;
  logic [BW_DIM-1:0]   step_n;
  logic [BW_DIM-1:0]   step_k;
  logic                step_first_k;
  logic                step_last_k;
  logic                step_last;
  logic                step_load;
  logic                step_done;
  logic [NUM_CH-1:0]   lsu_req_valid;
  logic [NUM_CH-1:0]   lsu_req_ready;
  logic [NUM_CH-1:0]   lsu_req_write;

  modport master (
    input  enable, inst_valid, inst_num_m, inst_num_n, inst_num_k,
           inst_ch_mask, inst_col_first, inst_load_acc,
           step_ready, step_done, lsu_req_ready,
    output busy, inst_ready, step_valid, step_m, step_n, step_k,
           step_first_k, step_last_k, step_last, step_load,
           lsu_req_valid, lsu_req_write
  );

  modport slave (
    output enable, inst_valid, inst_num_m, inst_num_n, inst_num_k,
           inst_ch_mask, inst_col_first, inst_load_acc,
           step_ready, step_done, lsu_req_ready,
    input  busy, inst_ready, step_valid, step_m, step_n, step_k,
           step_first_k, step_last_k, step_last, step_load,
           lsu_req_valid, lsu_req_write
  );
endinterface

// File: rtl/dca_block_sequencer_mc.sv
// ---------------------------------------------------------------------------
// dca_block_sequencer_mc
// Accepts one blocked-GEMM instruction and walks its M x N x K block space
// (k innermost; m or n outer depending on inst_col_first). Each block step
// is offered to the compute engine together with the matching LSU requests;
// the step and all its active LSU requests fire in the same cycle. A credit
// counter bounds the number of issued-but-not-completed steps.
// Ports:
//   clk, rst : clock, synchronous active-high reset (overrides enable)
//   bus      : dca_block_sequencer_mc_if.master (instruction, step, LSU)
// Channels 0..NUM_CH-2 are operand reads; channel NUM_CH-1 is the output
// channel (written on the last k step of a block).
// Optional feature macro: DCA_SEQ_LOAD_ACC_EN -- inserts an accumulator load
// step (output channel read) before every k == 0 compute step when the
// instruction asks for it. Undefined: inst_load_acc ignored, step_load = 0.
// ---------------------------------------------------------------------------
module dca_block_sequencer_mc #(
  parameter int NUM_CH          = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BW_DIM          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  dca_block_sequencer_mc_if.master  bus
);
  localparam int             CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0]  CRED_ONE = CW'(1);
  localparam int             OC       = NUM_CH - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_r, state_nxt_s;
  logic [BW_DIM-1:0]   m_r, n_r, k_r;
  logic [BW_DIM-1:0]   m_nxt_s, n_nxt_s, k_nxt_s;
  logic [BW_DIM-1:0]   num_m_r, num_n_r, num_k_r;
  logic [NUM_CH-1:0]   mask_r;
  logic                col_first_r;
  logic [CW-1:0]       credit_r;
  logic [NUM_CH-1:0]   active_s;
  logic                run_s, accept_s, load_s, fire_s, valid_s;
  logic                last_s, last_k_s, ready_ok_s, done_dec_s;

`ifdef DCA_SEQ_LOAD_ACC_EN
  logic load_acc_r;
  logic phase_r;
  assign load_s = run_s & phase_r;
`else
  logic unused_load_acc_s;
  assign unused_load_acc_s = bus.inst_load_acc;
  assign load_s = 1'b0;
`endif

  assign run_s      = (state_r == RUN);
  assign accept_s   = bus.inst_valid & (state_r == IDLE) & bus.enable;
  // Flags are gated with RUN so every step_* output reads 0 outside a walk.
  assign last_k_s   = run_s & ~load_s & (k_r == num_k_r);
  assign last_s     = last_k_s & (m_r == num_m_r) & (n_r == num_n_r);
  assign done_dec_s = bus.step_done & (credit_r != '0);

  // Active channel set of the step currently on offer.
  always_comb begin
    active_s = '0;
    for (int i = 0; i < OC; i++) begin
      active_s[i] = run_s & ~load_s & mask_r[i];
    end
    active_s[OC] = run_s & (load_s | (mask_r[OC] & last_k_s));
  end

  // An inactive channel never blocks; every active one must be ready.
  assign ready_ok_s = &(bus.lsu_req_ready | ~active_s);
  assign valid_s    = run_s & bus.enable & (credit_r < CRED_MAX) & ready_ok_s;
  assign fire_s     = valid_s & bus.step_ready;

  assign bus.step_valid    = valid_s;
  assign bus.lsu_req_valid = active_s & {NUM_CH{fire_s}};
  assign bus.lsu_req_write = {~load_s & active_s[OC] & fire_s, {(NUM_CH-1){1'b0}}};
  assign bus.inst_ready    = (state_r == IDLE);
  assign bus.busy          = (state_r != IDLE);
  assign bus.step_m        = m_r;
  assign bus.step_n        = n_r;
  assign bus.step_k        = k_r;
  assign bus.step_first_k  = run_s & (load_s | (k_r == '0));
  assign bus.step_last_k   = last_k_s;
  assign bus.step_last     = last_s;
  assign bus.step_load     = load_s;

  // Next block coordinates after a compute step fires; zeroed after the last.
  always_comb begin
    m_nxt_s = m_r;
    n_nxt_s = n_r;
    k_nxt_s = k_r;
    if (last_s) begin
      m_nxt_s = '0;
      n_nxt_s = '0;
      k_nxt_s = '0;
    end else if (k_r == num_k_r) begin
      k_nxt_s = '0;
      if (col_first_r) begin
        if (m_r == num_m_r) begin
          m_nxt_s = '0;
          n_nxt_s = n_r + BW_DIM'(1);
        end else begin
          m_nxt_s = m_r + BW_DIM'(1);
        end
      end else begin
        if (n_r == num_n_r) begin
          n_nxt_s = '0;
          m_nxt_s = m_r + BW_DIM'(1);
        end else begin
          n_nxt_s = n_r + BW_DIM'(1);
        end
      end
    end else begin
      k_nxt_s = k_r + BW_DIM'(1);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (fire_s && last_s) state_nxt_s = DRAIN;
        else                  state_nxt_s = RUN;
      end
      DRAIN: begin
        if (bus.enable && ((credit_r == '0) ||
                           ((credit_r == CRED_ONE) && bus.step_done)))
          state_nxt_s = IDLE;
        else
          state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Instruction fields and block coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r         <= '0;
      n_r         <= '0;
      k_r         <= '0;
      num_m_r     <= '0;
      num_n_r     <= '0;
      num_k_r     <= '0;
      mask_r      <= '0;
      col_first_r <= 1'b0;
    end else if (accept_s) begin
      m_r         <= '0;
      n_r         <= '0;
      k_r         <= '0;
      num_m_r     <= bus.inst_num_m;
      num_n_r     <= bus.inst_num_n;
      num_k_r     <= bus.inst_num_k;
      mask_r      <= bus.inst_ch_mask;
      col_first_r <= bus.inst_col_first;
    end else if (fire_s && !load_s) begin
      m_r <= m_nxt_s;
      n_r <= n_nxt_s;
      k_r <= k_nxt_s;
    end
  end

`ifdef DCA_SEQ_LOAD_ACC_EN
  // Load phase: set before each k == 0 compute step, cleared when the load fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_acc_r <= 1'b0;
      phase_r    <= 1'b0;
    end else if (accept_s) begin
      load_acc_r <= bus.inst_load_acc & bus.inst_ch_mask[OC];
      phase_r    <= bus.inst_load_acc & bus.inst_ch_mask[OC];
    end else if (fire_s) begin
      phase_r <= ~load_s & load_acc_r & ~last_s & (k_nxt_s == '0);
    end
  end
`endif

  // Outstanding-step credit: +1 per fire, -1 per completion, floor at 0.
  always_ff @(posedge clk) begin
    if (rst)                          credit_r <= '0;
    else if (fire_s && !done_dec_s)   credit_r <= credit_r + CRED_ONE;
    else if (!fire_s && done_dec_s)   credit_r <= credit_r - CRED_ONE;
  end
endmodule

// File: doc/dca_block_sequencer_mc.md
Name: dca_block_sequencer_mc

Overview:
- Parametrised successor to the NeuGEMM instruction sequencer.
- Accepts one blocked-GEMM instruction.
- Walks the M x N x K block space in a selectable loop order.
- Per block step, issues one step instruction to the compute engine and matching LSU requests on up to NUM_CH channels.
- Bounds steps in flight with a programmable credit counter.
- Sits between the instruction queue and the LSU/compute-engine array.

Parameters:
- NUM_CH, 3: LSU channel count, min 2. Channels 0..NUM_CH-2 are operand (read) channels; channel NUM_CH-1 is the output channel.
- MAX_OUTSTANDING, 4: maximum steps issued but not yet completed, min 1.
- BW_DIM, 8: width of each block-count field and step coordinate.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- enable  in  1  global advance qualifier; when 0, all state holds
- inst_valid  in  1  instruction offered
- inst_ready  out  1  instruction accepted when valid and ready
- inst_num_m  in  BW_DIM  M block count minus one
- inst_num_n  in  BW_DIM  N block count minus one
- inst_num_k  in  BW_DIM  K block count minus one
- inst_ch_mask  in  NUM_CH  per-channel enable; bit NUM_CH-1 enables output write/load
- inst_col_first  in  1  1: n is the outer loop, m the middle loop; 0: m outer, n middle; k is always innermost
- inst_load_acc  in  1  accumulator preload request; used only with the optional feature
- busy  out  1  state != IDLE
- step_valid  out  1  step offered to compute engine
- step_ready  in  1  compute engine accepts
- step_m, step_n, step_k  out  BW_DIM each  block coordinates
- step_first_k  out  1  k == 0
- step_last_k  out  1  k == num_k
- step_last  out  1  final compute step of instruction
- step_load  out  1  accumulator-load step (no compute)
- step_done  in  1  pulse: one issued step has completed
- lsu_req_valid  out  NUM_CH  per-channel request
- lsu_req_ready  in  NUM_CH  per-channel ready
- lsu_req_write  out  NUM_CH  1 = write; only bit NUM_CH-1 can be 1

Behaviour:
- Reset: clk-synchronous, active-high, overrides enable.
  - Reset values: state = IDLE; counters = 0; credit = 0; phase = 0.
  - Outputs at reset: inst_ready = 1, busy = 0, step_valid = 0, lsu_req_valid = 0, all step_* = 0.
  - rst asserted mid-instruction discards the instruction; no completion is signalled.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - inst_ready = 1.
  - On accept with enable = 1: latch all inst_* fields, clear m/n/k = 0, go to RUN.
  - Instruction-to-first-step_valid latency is 1 cycle.
- RUN, active-channel set:
  - Compute step: operand channel i (i < NUM_CH-1) is active iff mask[i].
  - Compute step: the output channel is active iff mask[NUM_CH-1] and step_last_k; it is then a write.
  - Load step: only the output channel is active, as a read.
- RUN, issue handshake:
  - step_valid = enable & (credit < MAX_OUTSTANDING) & AND(lsu_req_ready[a] over active channels).
  - lsu_req_valid[a] = step_valid & step_ready, for each active channel a.
  - step_valid does not depend on step_ready. Fire = step_valid & step_ready.
  - All active LSU requests and the step fire in the same cycle; no partial issue.
  - Coordinates and flags are stable while step_valid = 1 and the step has not fired.
- RUN, advance on fire:
  - k increments. At k == num_k, k wraps to 0 and the middle loop increments.
  - At middle == its max, the middle loop wraps and the outer loop increments.
  - Fire with step_last = 1 moves to DRAIN.
  - step_last = (m == num_m) & (n == num_n) & (k == num_k) & ~step_load.
  - All num fields = 0 gives exactly one step.
- Credit counter:
  - +1 on fire, -1 on step_done, unchanged on both in the same cycle.
  - Width is clog2(MAX_OUTSTANDING+1).
  - step_done at credit 0 is ignored (saturates at 0).
  - Fire is only permitted when credit < MAX_OUTSTANDING, so the counter never overflows.
- DRAIN: go to IDLE when credit == 0, or credit == 1 with step_done. inst_ready is 0 until IDLE.
- enable = 0: no fire, no transitions, counters hold. step_done pulses are still counted.

Optional Feature:
- Macro: DCA_SEQ_LOAD_ACC_EN.
- Defined:
  - When inst_load_acc = 1 and mask[NUM_CH-1] = 1, a load step is inserted before every k == 0 compute step.
  - The load step has step_load = 1, step_first_k = 1, step_last_k = 0, and uses 1 credit.
  - It uses a phase bit: phase = 1 is the load phase; after the load fires, phase = 0 and the compute k == 0 step follows.
  - step_last is never set on a load step.
- Undefined: inst_load_acc is ignored, step_load is tied to 0, no phase logic.

Test Plan:
1. NUM_CH = 3, num_m = 1, num_n = 0, num_k = 2, mask = 3'b111, row-first, step_ready = 1, all lsu ready, step_done 1 cycle after each fire:
   - 6 steps (m,k) = (0,0), (0,1), (0,2), (1,0), (1,1), (1,2).
   - lsu_req_valid[2] with write on the k = 2 steps only.
   - step_last on the 6th step; busy drops after the final done.
2. MAX_OUTSTANDING = 2, no step_done: exactly 2 fires, then step_valid = 0. One step_done → exactly one more fire.
3. lsu_req_ready[1] = 0 for 5 cycles with mask bit 1 set: no fire on any channel; fires the cycle after ready returns. Repeat with mask bit 1 clear: fires unaffected.
4. col_first = 1, num_m = 1, num_n = 1, num_k = 0: (m,n) order is (0,0), (1,0), (0,1), (1,1).
5. rst asserted mid-RUN with credit = 2: next cycle busy = 0, inst_ready = 1, step_valid = 0. A new instruction restarts at (0,0,0).
6. DCA_SEQ_LOAD_ACC_EN defined, inst_load_acc = 1, num_k = 1, single block:
   - Sequence: load step (channel 2 read only), compute k0, compute k1 with channel 2 write and step_last.
